// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner with press/release debounce and one-cycle code strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 50000,
  parameter int unsigned REPEAT_PERIOD   = 10000
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ROW_in,
  output logic [3:0] COL_drive,
  output logic [3:0] BCD_out,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {StScan, StDebounce, StPress, StHold, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_meta_q, rows_s;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       rows_lat_q, rows_lat_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic             hit;
  logic [1:0]       hit_row;
  logic [3:0]       code;
  logic             rep_fire;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_meta_q <= 4'hF;
      rows_s     <= 4'hF;
      state_q    <= StScan;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      rows_lat_q <= 4'hF;
      slot_q     <= '0;
      deb_q      <= '0;
    end else begin
      row_meta_q <= ROW_in;
      rows_s     <= row_meta_q;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rows_lat_q <= rows_lat_d;
      slot_q     <= slot_d;
      deb_q      <= deb_d;
    end
  end

  // Exactly one low row is a hit; anything else (idle or ghosting) is ignored.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    case (rows_s)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rows_lat_d = rows_lat_q;
    slot_d     = slot_q;
    deb_d      = deb_q;
    case (state_q)
      StScan: begin
        if (slot_q == SlotW'(SCAN_DIV - 1)) begin
          slot_d = '0;
          if (hit) begin
            state_d    = StDebounce;
            row_d      = hit_row;
            rows_lat_d = rows_s;
            deb_d      = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      StDebounce: begin
        if (rows_s != rows_lat_q) begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          slot_d  = '0;
        end else if (deb_q == DebW'(DEBOUNCE_CYCLES)) begin
          state_d = StPress;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StPress: state_d = StHold;
      StHold: begin
        if (&rows_s) begin
          state_d = StRelease;
          deb_d   = '0;
        end
      end
      StRelease: begin
        if (!(&rows_s)) begin
          state_d = StHold;
          deb_d   = '0;
        end else if (deb_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = StScan;
          col_d   = 2'd0;
          slot_d  = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_q, rep_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rep_q <= '0;
    else      rep_q <= rep_d;
  end

  // Countdown to the next repeat; it is only touched in PRESS/HOLD, so RELEASE freezes it.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    case (state_q)
      StPress: rep_d = RepW'(REPEAT_DELAY - 1);
      StHold: begin
        if (rep_q == '0) begin
          rep_fire = 1'b1;
          rep_d    = RepW'(REPEAT_PERIOD - 1);
        end else begin
          rep_d = rep_q - 1'b1;
        end
      end
      default: ;
    endcase
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    code = 4'h0;
    case ({row_q, col_q})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
  end

  assign COL_drive = ~(4'b0001 << col_q);
  assign key_valid = (state_q == StPress) || rep_fire;
  assign BCD_out   = key_valid ? code : 4'h0;
  assign key_held  = (state_q == StPress) || (state_q == StHold) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: keypad matrix model, keymap/latency reference,
// randomized presses. Build with +define+KEYPAD_REPEAT_EN to check auto-repeat.
module tb_keypad_encoder;

  localparam int unsigned ScanDiv   = 4;
  localparam int unsigned DebCycles = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepDelay  = 40;
  localparam int unsigned RepPeriod = 20;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] ROW_in;
  logic [3:0] COL_drive;
  logic [3:0] BCD_out;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          strobes = 0;
  logic        prev_valid = 1'b0;

  always #5 CLK = ~CLK;

  keypad_encoder #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_CYCLES(DebCycles)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY   (RepDelay),
    .REPEAT_PERIOD  (RepPeriod)
`endif
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ROW_in   (ROW_in),
    .COL_drive(COL_drive),
    .BCD_out  (BCD_out),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    ROW_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !COL_drive[c]) ROW_in[r] = 1'b0;
  end

  // Strobe invariants checked on every falling edge while out of reset.
  always @(negedge CLK) begin
    if (RST) begin
      checks++;
      if (key_valid && prev_valid) begin
        failures++;
        $display("FAIL valid_twice: key_valid high two cycles in a row, got 1 expected 0");
      end
      checks++;
      if (!key_valid && BCD_out !== 4'h0) begin
        failures++;
        $display("FAIL bcd_idle: BCD_out got %h expected 0", BCD_out);
      end
      if (key_valid) strobes++;
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic logic [3:0] key_code(input int r, input int c);
    logic [3:0] tbl [16];
    tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    return tbl[r*4+c];
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_col(input int c, input bit want_eq, input int limit, output bit ok);
    int n = 0;
    while (((COL_drive == col_pat(c)) != want_eq) && n < limit) begin
      tick();
      n++;
    end
    ok = ((COL_drive == col_pat(c)) == want_eq);
  endtask

  task automatic wait_strobe(input int limit, output bit ok, output int waited);
    waited = 0;
    while (!key_valid && waited < limit) begin
      tick();
      waited++;
    end
    ok = key_valid;
  endtask

  // Close key (r,c) just before its column slot begins; returns on the first cycle of that slot.
  task automatic arm_key(input int r, input int c, output bit ok);
    bit ok1;
    wait_col(c, 1'b0, 40, ok1);
    pressed = 16'(1) << (r*4+c);
    wait_col(c, 1'b1, 40, ok);
    ok = ok & ok1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL arm_key: column %0d slot not reached, got %b expected %b", c, COL_drive,
               col_pat(c));
    end
  endtask

  task automatic release_idle();
    int n = 0;
    pressed = '0;
    while (key_held && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL release_idle: key_held got %b expected 0", key_held);
    end
    ticks(2);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    pressed = '0;
    ticks(3);
    checks += 4;
    if (COL_drive !== 4'b1110) begin
      failures++; $display("FAIL reset_col: got %b expected 1110", COL_drive);
    end
    if (BCD_out !== 4'h0) begin
      failures++; $display("FAIL reset_bcd: got %h expected 0", BCD_out);
    end
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", key_valid);
    end
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL reset_held: got %b expected 0", key_held);
    end
    RST = 1'b1;
    for (int i = 0; i < 4 * 4 * int'(ScanDiv); i++) begin
      checks++;
      if (COL_drive !== col_pat((i / int'(ScanDiv)) % 4)) begin
        failures++;
        $display("FAIL scan_rotate[%0d]: got %b expected %b", i, COL_drive,
                 col_pat((i / int'(ScanDiv)) % 4));
      end
      tick();
    end
  endtask

  task automatic test_press(input int r, input int c);
    bit ok;
    int waited;
    int base;
    int hold;
    base = strobes;
    arm_key(r, c, ok);
    if (!ok) return;
    wait_strobe(100, ok, waited);
    checks++;
    if (!ok || waited != int'(ScanDiv + DebCycles + 1)) begin
      failures++;
      $display("FAIL press_latency(%0d,%0d): got %0d expected %0d", r, c, waited,
               ScanDiv + DebCycles + 1);
    end
    checks++;
    if (BCD_out !== key_code(r, c)) begin
      failures++;
      $display("FAIL press_code(%0d,%0d): got %h expected %h", r, c, BCD_out, key_code(r, c));
    end
    hold = int'($urandom_range(3, 20));
    ticks(hold);
    checks++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL press_held(%0d,%0d): got %b expected 1", r, c, key_held);
    end
    // Release needs 2 sync cycles, one HOLD sample and DebCycles in RELEASE.
    pressed = '0;
    for (int i = 1; i <= int'(DebCycles) + 3; i++) begin
      tick();
      if (i == int'(DebCycles) + 2) begin
        checks++;
        if (key_held !== 1'b1) begin
          failures++; $display("FAIL release_early: key_held got %b expected 1", key_held);
        end
      end
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL release_late: key_held got %b expected 0", key_held);
    end
    checks++;
    if (strobes - base != 1) begin
      failures++; $display("FAIL press_count(%0d,%0d): got %0d expected 1", r, c, strobes - base);
    end
    ticks(2);
  endtask

  task automatic test_bounce();
    bit ok;
    int waited;
    int base;
    base = strobes;
    arm_key(3, 1, ok);
    if (!ok) return;
    ticks(6);
    pressed = '0;
    ticks(3);
    pressed = 16'(1) << 13;
    wait_col(1, 1'b0, 20, ok);
    checks++;
    if (COL_drive !== col_pat(2)) begin
      failures++; $display("FAIL bounce_resume: got %b expected %b", COL_drive, col_pat(2));
    end
    checks++;
    if (strobes != base) begin
      failures++; $display("FAIL bounce_strobe: got %0d expected 0", strobes - base);
    end
    wait_strobe(200, ok, waited);
    checks++;
    if (!ok || BCD_out !== 4'h0) begin
      failures++; $display("FAIL bounce_press: valid %b code %h expected 1 0", key_valid, BCD_out);
    end
    release_idle();
    checks++;
    if (strobes - base != 1) begin
      failures++; $display("FAIL bounce_count: got %0d expected 1", strobes - base);
    end
  endtask

  task automatic test_release_glitch();
    bit ok;
    int waited;
    int base;
    int r;
    int c;
    logic [15:0] key;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    key = 16'(1) << (r*4+c);
    base = strobes;
    arm_key(r, c, ok);
    if (!ok) return;
    wait_strobe(100, ok, waited);
    ticks(3);
    pressed = '0;
    ticks(3);
    pressed = key;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (key_held !== 1'b1) begin
        failures++; $display("FAIL glitch_held[%0d]: got %b expected 1", i, key_held);
      end
    end
    checks++;
    if (strobes - base != 1) begin
      failures++; $display("FAIL glitch_count: got %0d expected 1", strobes - base);
    end
    release_idle();
  endtask

  task automatic test_ghost();
    int base;
    int c;
    int r;
    c = int'($urandom_range(0, 3));
    r = int'($urandom_range(0, 3));
    base = strobes;
    pressed = (16'(1) << (r*4+c)) | (16'(1) << (((r + 2) % 4)*4+c));
    ticks(3 * 4 * int'(ScanDiv));
    checks += 2;
    if (strobes != base) begin
      failures++; $display("FAIL ghost_strobe: got %0d expected 0", strobes - base);
    end
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL ghost_held: got %b expected 0", key_held);
    end
    pressed = '0;
    ticks(3);
    test_press(r, c);
  endtask

  task automatic test_repeat();
    bit ok;
    int waited;
    int got[$];
    int exp[$];
    arm_key(3, 3, ok);
    if (!ok) return;
    wait_strobe(100, ok, waited);
    checks++;
    if (!ok || BCD_out !== 4'hD) begin
      failures++; $display("FAIL repeat_first: valid %b code %h expected 1 d", key_valid, BCD_out);
    end
`ifdef KEYPAD_REPEAT_EN
    for (int t = int'(RepDelay); t <= 100; t += int'(RepPeriod)) exp.push_back(t);
`endif
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (key_valid) begin
        got.push_back(i);
        checks++;
        if (BCD_out !== 4'hD) begin
          failures++; $display("FAIL repeat_code at +%0d: got %h expected d", i, BCD_out);
        end
      end
    end
    checks++;
    if (got.size() != exp.size()) begin
      failures++; $display("FAIL repeat_count: got %0d expected %0d", got.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (got[i] != exp[i]) begin
          failures++; $display("FAIL repeat_time[%0d]: got +%0d expected +%0d", i, got[i], exp[i]);
        end
      end
    end
    release_idle();
  endtask

  task automatic test_reset_midop();
    bit ok;
    int waited;
    int r;
    int c;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    arm_key(r, c, ok);
    if (!ok) return;
    wait_strobe(100, ok, waited);
    ticks(5);
    #2;
    RST = 1'b0;
    #1;
    checks += 3;
    if (COL_drive !== 4'b1110) begin
      failures++; $display("FAIL midop_col: got %b expected 1110", COL_drive);
    end
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL midop_held: got %b expected 0", key_held);
    end
    if (key_valid !== 1'b0 || BCD_out !== 4'h0) begin
      failures++; $display("FAIL midop_out: got %b/%h expected 0/0", key_valid, BCD_out);
    end
    tick();
    RST = 1'b1;
    wait_strobe(100, ok, waited);
    checks++;
    if (!ok || BCD_out !== key_code(r, c)) begin
      failures++;
      $display("FAIL midop_redetect: valid %b code %h expected 1 %h", key_valid, BCD_out,
               key_code(r, c));
    end
    release_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    test_press(1, 3);
    test_bounce();
    test_release_glitch();
    test_ghost();
    test_repeat();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 active-low matrix keypad, debounces presses and emits one 4-bit key code per press on `BCD_out` with a single-cycle `key_valid` strobe. It is the producer side of the login/management path: `BCD_out` drives the `BCD_input` port of `management`, which consumes digits 0-9 and the command codes 4'b1011 (start) and 4'b1101 (enter).

## Interface
- `SCAN_DIV`, 16: clock cycles each column stays driven (min 4).
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required for press and for release (min 2).
- `REPEAT_DELAY`, 50000: held cycles after the first strobe before auto-repeat starts. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, 10000: cycles between auto-repeat strobes. Used only with `KEYPAD_REPEAT_EN`.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `ROW_in`  in  4  keypad rows, active-low with external pull-ups, asynchronous to `CLK`.
- `COL_drive`  out  4  one-hot-low column drive.
- `BCD_out`  out  4  key code during the `key_valid` cycle, 4'b0000 otherwise.
- `key_valid`  out  1  one-cycle strobe per accepted press or repeat.
- `key_held`  out  1  high from the press strobe until release is debounced.

## Operation
- `ROW_in` always passes through a 2-flop synchronizer. All logic uses the synchronized value `rows_s`.
- Keymap by row/column (r,c), codes in hex:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- A hit means exactly one bit of `rows_s` is low. Zero or several low bits count as no hit. Multi-key ghosting is ignored.
- FSM states: SCAN, DEBOUNCE, PRESS, HOLD, RELEASE.
- SCAN:
  - Drive column k low for `SCAN_DIV` cycles, sampling `rows_s` on the last cycle of the slot.
  - No hit: advance k = (k+1) mod 4.
  - Hit: latch (row, k), hold column k, go to DEBOUNCE.
- DEBOUNCE:
  - The counter runs while `rows_s` equals the latched pattern.
  - Any mismatch returns to SCAN at column k+1.
  - After `DEBOUNCE_CYCLES` matches, go to PRESS.
- PRESS: lasts one cycle. `key_valid`=1, `BCD_out`=code, `key_held` set. Then go to HOLD.
- HOLD: column k stays driven. When `rows_s` is all-ones, go to RELEASE.
- RELEASE:
  - `DEBOUNCE_CYCLES` consecutive all-ones cycles clear `key_held` and return to SCAN at column 0.
  - Any low row bit returns to HOLD with the counter cleared.
  - No new strobe is issued in this case; a bounce is not a new press.
- Reset mid-operation aborts any state immediately. A key still held after reset is re-detected as a new press.

## Timing
- Reset values:
  - `COL_drive`=4'b1110, `BCD_out`=4'b0000, `key_valid`=0, `key_held`=0.
  - State SCAN, column 0, all counters 0.
- Pin-to-`rows_s` latency: 2 cycles.
- `key_valid` rises exactly `DEBOUNCE_CYCLES`+1 cycles after the edge that sampled the hit. It is never high two consecutive cycles.
- `BCD_out` is nonzero only while `key_valid`=1. Digit 0 is distinguishable only by `key_valid`.
- Full scan period without a hit: 4×`SCAN_DIV` cycles.
- Counters saturate. No wrap-around is permitted inside a debounce or repeat interval.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HOLD, a continuous press emits a repeat strobe (same code, one cycle) `REPEAT_DELAY` cycles after the PRESS strobe.
  - Further repeat strobes follow every `REPEAT_PERIOD` cycles.
  - Entering RELEASE freezes the repeat counter. Returning to HOLD resumes it without emitting.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one strobe per press.
  - Repeat parameters and the repeat counter are not synthesized.

## Test plan
Parameters for all scenarios: `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=40, `REPEAT_PERIOD`=20.

- Reset with `RST`=0 and `ROW_in`=4'b1111 → `COL_drive`=4'b1110, `BCD_out`=0, `key_valid`=0. After release, columns rotate 1110→1101→1011→0111, 4 cycles each.
- Hold (r1,c3) low across scan and debounce → exactly one `key_valid` with `BCD_out`=4'b1011, 9 cycles after the hit sample. `key_held`=1 until 8 released cycles have passed.
- Bounce (r3,c1) for 3 cycles during DEBOUNCE → no strobe, scan resumes at column 2. A stable press → one strobe with `BCD_out`=4'b0000 and `key_valid`=1.
- Release glitch of 3 cycles while in HOLD → no second strobe, `key_held` stays 1.
- Two rows low in the same column → no strobe. Release plus one row low → one normal strobe.
- With `KEYPAD_REPEAT_EN`, hold (r3,c3) for 100 cycles after the first strobe → strobes with 4'b1101 at +0, +40, +60, +80, +100. Without the macro → a single strobe.
